// File: rtl/vli_decoder.sv
// vli_decoder: JPEG variable-length-integer (VLI) magnitude decoder.
// Turns a (size, symbol) pair from the Huffman stage into a signed coefficient.
// There is one registered result per accepted input, with a fixed latency of one cycle.
module vli_decoder #(
    parameter int SIZE_W = 4,
    parameter int SYM_W  = 11,
    parameter int VAL_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [SIZE_W-1:0] size,
    input  logic [SYM_W-1:0]  symbol,
    output logic              out_valid,
    output logic [VAL_W-1:0]  value,
    output logic              size_err
);

    logic [SYM_W-1:0] size_mask;
    logic [SYM_W-1:0] sym_masked;
    logic             sym_msb;
    logic             size_over;
    logic [VAL_W-1:0] dec_value;

    logic             out_valid_d, out_valid_q;
    logic [VAL_W-1:0] value_d,     value_q;
    logic             size_err_d,  size_err_q;

    // Decode stage: mask symbol to 'size' bits, then apply the JPEG sign rule.
    always_comb begin
        // NOTE: every signal written here gets a default before any branch, so no latch is inferred.
        size_mask = '0;
        sym_msb   = 1'b0;
        for (int i = 0; i < SYM_W; i++) begin
            size_mask[i] = (i < int'(size));
            if (i + 1 == int'(size)) begin
                sym_msb = symbol[i];
            end
        end
        sym_masked = symbol & size_mask;
        size_over  = (int'(size) > SYM_W);

        if (size_over || (size == '0)) begin
            dec_value = '0;
        end else if (sym_msb) begin
            // Leading one: the masked bits are the positive magnitude.
            dec_value = VAL_W'(sym_masked);
        end else begin
            // Leading zero: the value is negative, m - (2^size - 1), and size_mask is 2^size - 1.
            dec_value = VAL_W'(sym_masked) - VAL_W'(size_mask);
        end
    end

    // Next-state: valid follows in_valid; the payload holds while no input is accepted.
    always_comb begin
        out_valid_d = in_valid;
        value_d     = value_q;
        size_err_d  = size_err_q;
        if (in_valid) begin
            value_d    = dec_value;
            size_err_d = size_over;
        end
    end

    // Output register with synchronous reset. Reset wins over a coincident input.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
        if (reset) begin
            out_valid_q <= 1'b0;
            value_q     <= '0;
            size_err_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            value_q     <= value_d;
            size_err_q  <= size_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign value     = value_q;
    assign size_err  = size_err_q;

endmodule

// File: tb/tb_vli_decoder.sv
// tb_vli_decoder: table-driven and scoreboard-checked bench for vli_decoder.
module tb_vli_decoder;

    localparam int SIZE_W = 4;
    localparam int SYM_W  = 11;
    localparam int VAL_W  = 12;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [SIZE_W-1:0] size;
    logic [SYM_W-1:0]  symbol;
    logic              out_valid;
    logic [VAL_W-1:0]  value;
    logic              size_err;

    vli_decoder #(.SIZE_W(SIZE_W), .SYM_W(SYM_W), .VAL_W(VAL_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .size      (size),
        .symbol    (symbol),
        .out_valid (out_valid),
        .value     (value),
        .size_err  (size_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [SIZE_W-1:0] size;
        logic [SYM_W-1:0]  sym;
        int                exp_val;
        logic              exp_err;
    } vec_t;

    typedef struct {
        logic [VAL_W-1:0] val;
        logic             err;
    } exp_t;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    // Expected-output state kept by the bench.
    logic             exp_valid = 1'b0;
    logic [VAL_W-1:0] last_val  = '0;
    logic             last_err  = 1'b0;
    bit               started   = 1'b0;

    task automatic check(input string name, input bit ok, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Independent reference: the JPEG VLI rule written with integer arithmetic.
    function automatic exp_t ref_decode(input int sz, input int sym);
        exp_t r;
        int   m;
        int   v;
        r.err = 1'b0;
        v     = 0;
        if (sz > SYM_W) begin
            r.err = 1'b1;
        end else if (sz != 0) begin
            m = sym % (1 << sz);
            if (m >= (1 << (sz - 1))) v = m;
            else                      v = m - ((1 << sz) - 1);
        end
        r.val = VAL_W'(v);
        return r;
    endfunction

    // Drive one cycle of stimulus #1 after the edge; queue the expectation if it will be accepted.
    task automatic drive(input bit rst, input bit v, input int sz, input int sym,
                         input int exp_val, input bit exp_err);
        exp_t e;
        @(posedge clk);
        #1;
        reset    = rst;
        in_valid = v;
        size     = SIZE_W'(sz);
        symbol   = SYM_W'(sym);
        if (v && !rst) begin
            e.val = VAL_W'(exp_val);
            e.err = exp_err;
            sb_q.push_back(e);
        end
    endtask

    // Record, at each edge, what the registered outputs must show afterwards.
    always @(posedge clk) begin
        exp_valid = in_valid && !reset;
        if (reset) begin
            started  = 1'b1;
            last_val = '0;
            last_err = 1'b0;
        end
    end

    // Monitor: sample outputs at the falling edge and compare them with the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            check("out_valid", out_valid === exp_valid, int'(out_valid), int'(exp_valid));
            if (out_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", 1'b0, int'($signed(value)), 0);
                end else begin
                    e = sb_q.pop_front();
                    check("value", value === e.val, int'($signed(value)), int'($signed(e.val)));
                    check("size_err", size_err === e.err, int'(size_err), int'(e.err));
                    last_val = e.val;
                    last_err = e.err;
                end
            end else begin
                check("hold_value", value === last_val, int'($signed(value)), int'($signed(last_val)));
                check("hold_size_err", size_err === last_err, int'(size_err), int'(last_err));
            end
        end
    end

    vec_t vecs[$];

    initial begin
        exp_t r;
        int   sz;
        int   sym;

        vecs.push_back('{4'd3,  11'h007,  7,     1'b0});
        vecs.push_back('{4'd0,  11'h001,  0,     1'b0});
        vecs.push_back('{4'd1,  11'h001,  1,     1'b0});
        vecs.push_back('{4'd1,  11'h000, -1,     1'b0});
        vecs.push_back('{4'd10, 11'h000, -1023,  1'b0});
        vecs.push_back('{4'd11, 11'h000, -2047,  1'b0});
        vecs.push_back('{4'd11, 11'h7FF,  2047,  1'b0});
        vecs.push_back('{4'd3,  11'h018, -7,     1'b0});
        vecs.push_back('{4'd3,  11'h01F,  7,     1'b0});
        vecs.push_back('{4'd3,  11'h015,  5,     1'b0});
        vecs.push_back('{4'd4,  11'h7F6, -9,     1'b0});
        vecs.push_back('{4'd13, 11'h7FF,  0,     1'b1});
        vecs.push_back('{4'd12, 11'h123,  0,     1'b1});
        vecs.push_back('{4'd15, 11'h000,  0,     1'b1});
        vecs.push_back('{4'd2,  11'h002,  2,     1'b0});

        // Hold reset for two cycles, with in_valid low.
        reset    = 1'b1;
        in_valid = 1'b0;
        size     = '0;
        symbol   = '0;
        repeat (2) @(posedge clk);

        // Back-to-back table vectors.
        foreach (vecs[i]) begin
            drive(1'b0, 1'b1, int'(vecs[i].size), int'(vecs[i].sym), vecs[i].exp_val, vecs[i].exp_err);
        end

        // One-cycle bubble: outputs must hold, then resume streaming.
        drive(1'b0, 1'b0, 3, 7, 0, 1'b0);
        drive(1'b0, 1'b1, 1, 0, -1, 1'b0);
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
        drive(1'b0, 1'b0, 11, 0, 0, 1'b0);
        drive(1'b0, 1'b1, 13, 0, 0, 1'b1);
        drive(1'b0, 1'b1, 11, 11'h400, 1024, 1'b0);

        // Random stream with occasional bubbles, checked against the reference model.
        for (int k = 0; k < 60; k++) begin
            sz  = $urandom_range(0, 15);
            sym = $urandom_range(0, 2047);
            r   = ref_decode(sz, sym);
            drive(1'b0, ($urandom_range(0, 3) != 0), sz, sym, int'($signed(r.val)), r.err);
        end

        // Let the pipeline drain before the reset-with-valid case.
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0);

        // Reset asserted together with in_valid: the input is dropped and the outputs clear.
        drive(1'b1, 1'b1, 3, 7, 7, 1'b0);
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);

        check("scoreboard_drained", sb_q.size() == 0, sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
